led_trail_pwm: RTL and testbench
================================

Name: led_trail_pwm

Overview:
- Sits directly downstream of the chaser pattern generator and drives the LED row pins.
- Takes the generator's 8-bit pattern and its slow step clock, and gives each LED a brightness level.
- A lit LED is set to full brightness; an unlit LED decays geometrically on every step, producing a fading meteor tail.
- Levels are rendered through a free-running PWM counter on the fast system clock.

Parameters:
- BW, 4: brightness level width. MAX = 2^BW-1 (15 at default).
- DECAY_SHIFT, 1: right-shift applied to an unlit LED's level on each step. Legal range 1..BW.

Ports:
- clk  in  1  system clock (fast board clock)
- reset  in  1  asynchronous, active-high reset; clears all state immediately
- tick_in  in  1  slow step clock from the frequency divider, treated as asynchronous data; pattern changes on its rising edge
- pattern_in  in  8  current chaser pattern; bit i = LED i lit
- enable  in  1  synchronous output enable; low blanks led_out
- led_out  out  8  registered PWM drive, 1 = LED on
- pwm_wrap  out  1  registered single-cycle pulse when the PWM counter wraps

Behaviour:
- Reset values: led_out=0x00, pwm_wrap=0, all 8 levels=0, PWM counter=0, sync flops s1/s2/s3=0.
- Step synchronizer and detector:
  - tick_in passes through s1->s2; s3 holds the previous s2.
  - step = s2 & ~s3, combinational.
  - If tick_in is first sampled high at edge E0, then s2=1 after E1 and step is high during the cycle after E1.
  - Levels and pattern_in are sampled at E2.
  - tick_in held high for N cycles produces exactly one step. A glitch shorter than one clk period may be missed; this is acceptable.
  - pattern_in must be stable by E2. It is, because the generator updates on the tick_in rising edge.
- Level update, only at an edge where step=1, for each i:
  - pattern_in[i]=1: level[i] <= MAX.
  - pattern_in[i]=0: level[i] <= level[i] >> DECAY_SHIFT.
  - With no step, levels hold.
  - Default decay sequence: 15, 7, 3, 1, 0, then stays at 0.
- PWM counter:
  - Counts 0..MAX-1 and wraps to 0, giving a period of MAX cycles (15).
  - pwm_wrap is registered high for exactly the one cycle following the edge where the counter goes MAX-1 -> 0.
  - The counter runs regardless of enable and is not reset by steps.
- Output:
  - led_out[i] <= enable & (eff_level[i] > cnt), registered.
  - eff_level is the level itself unless the optional feature is enabled.
  - Level MAX: always on. Level 0: always off. Level L: on for L of every MAX cycles, at counter values 0..L-1.
  - A level changed at E2 is first reflected on led_out at E3.
  - enable low: led_out=0 from the next edge; levels and counter keep updating.
- Simultaneous step and counter wrap: the compare at that edge uses the old levels; no special case.
- Reset asserted mid-period or mid-sync: every register clears asynchronously. After release, the first step needs a fresh tick_in rising edge seen through the synchronizer. A tick_in that is already high at release counts as a rising edge, because s3=0.

Optional Feature:
- Macro: LED_GAMMA_EN.
- Defined: eff_level = (level*level) >> BW, computed at 2*BW bits, with eff_level forced to MAX when level=MAX.
  - BW=4 mapping: 15->15, 7->3, 3->0, 8->4.
  - Gives a perceptually steeper tail.
- Undefined: eff_level = level, a linear compare with no multiplier.
- Step timing and decay arithmetic are identical in both builds.

Test Plan:
- Reset, then tick_in rises with pattern_in=0xE0 -> starting 3 cycles after tick_in is first sampled high, led_out=0xE0 on every cycle of a 15-cycle period.
- Second tick with pattern_in=0x70, linear build -> LED7 level 7: on at cnt 0..6 and off at 7..14. LEDs 6..4 on continuously. LEDs 3..0 off.
- Five steps with bit 7 clear after it was set -> LED7 on-count per period goes 15, 7, 3, 1, 0, then stays 0. tick_in held high for 40 cycles -> only one decrement.
- Free run -> pwm_wrap high for exactly 1 cycle every 15 cycles. Drop enable mid-period -> led_out=0x00 from the next edge while levels keep decaying; raising enable restores the expected pattern.
- Assert reset mid-period with levels nonzero -> led_out=0x00, pwm_wrap=0 immediately. After release, no level change until a new tick edge.
- LED_GAMMA_EN defined, level 7 -> on for 3 of 15 cycles. Level 15 -> on for all 15.

Source files
------------

// File: rtl/led_trail_pwm_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : led_trail_pwm_if                                            |
// | Purpose  : Pattern/tick inputs and PWM LED outputs of led_trail_pwm.   |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+

interface led_trail_pwm_if;
  logic       tick_in;
  logic [7:0] pattern_in;
  logic       enable;
  logic [7:0] led_out;
  logic       pwm_wrap;

  modport master (
    output tick_in,
    output pattern_in,
    output enable,
    input  led_out,
    input  pwm_wrap
  );

  modport slave (
    input  tick_in,
    input  pattern_in,
    input  enable,
    output led_out,
    output pwm_wrap
  );
endinterface

`default_nettype wire

// File: rtl/led_trail_pwm.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : led_trail_pwm                                               |
// | Purpose  : Per-LED fading brightness driven by chaser steps, rendered  |
// |            through a free-running PWM counter. LED_GAMMA_EN selects a  |
// |            squared brightness curve for the compare.                   |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+

module led_trail_pwm #(
  parameter int BW          = 4,
  parameter int DECAY_SHIFT = 1
) (
  input  wire logic      clk,
  input  wire logic      reset,
  led_trail_pwm_if.slave bus
);

  localparam int            NLED      = 8;
  localparam logic [BW-1:0] MAX_LEVEL = {BW{1'b1}};
  localparam logic [BW-1:0] CNT_LAST  = BW'((1 << BW) - 2);

  // tick_in is asynchronous: two flops to synchronize, a third for edge detect
  logic s1_q, s2_q, s3_q;
  logic step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.tick_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign step = s2_q & ~s3_q;

  logic [BW-1:0] cnt_q, cnt_d;
  logic          wrap_q, wrap_d;
  logic [NLED-1:0] lit;
  logic [NLED-1:0] led_q, led_d;

  for (genvar i = 0; i < NLED; i++) begin : g_led
    logic [BW-1:0] level_q, level_d;
    logic [BW-1:0] eff_level;

    always_comb begin
      level_d = level_q;
      if (step) begin
        level_d = bus.pattern_in[i] ? MAX_LEVEL : (level_q >> DECAY_SHIFT);
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        level_q <= '0;
      end else begin
        level_q <= level_d;
      end
    end

`ifdef LED_GAMMA_EN
    logic [2*BW-1:0] square;

    // Pin full scale to MAX so a lit LED stays on for the whole period
    assign square    = {{BW{1'b0}}, level_q} * {{BW{1'b0}}, level_q};
    assign eff_level = (level_q == MAX_LEVEL) ? MAX_LEVEL : square[2*BW-1:BW];
`else
    assign eff_level = level_q;
`endif

    assign lit[i] = (eff_level > cnt_q);
  end

  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    wrap_d = (cnt_q == CNT_LAST);
    led_d  = bus.enable ? lit : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      led_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      led_q  <= led_d;
    end
  end

  assign bus.led_out  = led_q;
  assign bus.pwm_wrap = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_led_trail_pwm.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_led_trail_pwm                                            |
// | Purpose  : Directed stimulus with a per-PWM-period scoreboard.         |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+

module tb_led_trail_pwm;

  logic clk = 1'b0;
  logic reset;

  led_trail_pwm_if bus ();

  led_trail_pwm #(
    .BW          (4),
    .DECAY_SHIFT (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // lv holds one level nibble per LED, LED i at bits 4*i+3:4*i
  typedef struct packed {
    logic        en;
    logic [31:0] lv;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [3:0] eff(input logic [3:0] l);
`ifdef LED_GAMMA_EN
    logic [7:0] sq;
    sq = {4'd0, l} * {4'd0, l};
    return (l == 4'hF) ? 4'hF : sq[7:4];
`else
    return l;
`endif
  endfunction

  function automatic logic [7:0] exp_byte(input exp_t e, input int k);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b[i] = e.en && (int'(eff(e.lv[4*i +: 4])) > k);
    end
    return b;
  endfunction

  // Monitor: one wrap pulse closes a period whose samples are cnt 0..14
  logic [7:0] trace [15];
  int         idx = 0;
  int         since = 0;
  bit         armed = 0;
  bit         seen_wrap = 0;
  exp_t       mon_e;
  int         mon_bad;

  always @(negedge clk) begin
    if (reset) begin
      idx       = 0;
      since     = 0;
      armed     = 0;
      seen_wrap = 0;
    end else begin
      if (idx < 15) trace[idx] = bus.led_out;
      idx++;
      since++;
      if (bus.pwm_wrap) begin
        if (seen_wrap) begin
          checks++;
          if (since != 15) begin
            errors++;
            $display("FAIL wrap_period: got %0d cycles between pulses, want 15", since);
          end
        end
        if (armed) begin
          mon_e   = exp_q.pop_front();
          mon_bad = 0;
          checks++;
          for (int k = 0; k < 15; k++) begin
            if (mon_bad == 0 && trace[k] !== exp_byte(mon_e, k)) begin
              mon_bad = 1;
              errors++;
              $display("FAIL period_trace: cnt=%0d led_out=%02h want %02h (levels=%08h en=%0d)",
                       k, trace[k], exp_byte(mon_e, k), mon_e.lv, mon_e.en);
            end
          end
        end
        armed     = (exp_q.size() > 0);
        idx       = 0;
        since     = 0;
        seen_wrap = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %02h want %02h", name, act, want);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d entries pending after %0d cycles, want 0",
               exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic expect_levels(input logic [31:0] lv, input logic en);
    repeat (8) @(negedge clk);
    @(posedge clk);
    exp_q.push_back({en, lv});
    drain();
  endtask

  task automatic do_tick(input logic [7:0] p, input int hold);
    @(negedge clk);
    bus.pattern_in = p;
    bus.tick_in    = 1'b1;
    repeat (hold) @(negedge clk);
    bus.tick_in = 1'b0;
  endtask

  task automatic wait_wrap();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.pwm_wrap && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.pwm_wrap) begin
      checks++;
      errors++;
      $display("FAIL wrap_timeout: got no pwm_wrap in %0d cycles, want one within 15", n);
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.tick_in    = 1'b0;
    bus.pattern_in = 8'h00;
    bus.enable     = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_led_out", bus.led_out, 8'h00);
    chk("reset_pwm_wrap", {7'd0, bus.pwm_wrap}, 8'h00);
    #2 reset = 1'b0;
    repeat (20) @(negedge clk);
    expect_levels(32'h0000_0000, 1'b1);

    // First step: new levels reach led_out at the third edge after sampling
    @(negedge clk);
    bus.pattern_in = 8'hE0;
    bus.tick_in    = 1'b1;
    repeat (3) @(negedge clk);
    chk("tick_latency_E2", bus.led_out, 8'h00);
    @(negedge clk);
    chk("tick_latency_E3", bus.led_out, 8'hE0);
    bus.tick_in = 1'b0;
    expect_levels(32'hFFF0_0000, 1'b1);

    do_tick(8'h70, 4);
    expect_levels(32'h7FFF_0000, 1'b1);
    do_tick(8'h70, 40);
    expect_levels(32'h3FFF_0000, 1'b1);
    do_tick(8'h0F, 4);
    expect_levels(32'h1777_FFFF, 1'b1);
    do_tick(8'h00, 4);
    expect_levels(32'h0333_7777, 1'b1);
    do_tick(8'h00, 4);
    expect_levels(32'h0111_3333, 1'b1);

    // Blank output right at cnt=0 where enabled LEDs would otherwise be lit
    wait_wrap();
    bus.enable = 1'b0;
    @(negedge clk);
    chk("enable_drop_next_edge", bus.led_out, 8'h00);
    do_tick(8'h80, 4);
    expect_levels(32'hF000_1111, 1'b0);
    @(negedge clk);
    bus.enable = 1'b1;
    expect_levels(32'hF000_1111, 1'b1);

    do_tick(8'hFF, 4);
    expect_levels(32'hFFFF_FFFF, 1'b1);
    wait_wrap();
    #2;
    chk("pre_reset_led_out", bus.led_out, 8'hFF);
    chk("pre_reset_pwm_wrap", {7'd0, bus.pwm_wrap}, 8'h01);
    reset = 1'b1;
    #1;
    chk("async_reset_led_out", bus.led_out, 8'h00);
    chk("async_reset_pwm_wrap", {7'd0, bus.pwm_wrap}, 8'h00);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    repeat (40) @(negedge clk);
    expect_levels(32'h0000_0000, 1'b1);
    do_tick(8'h81, 4);
    expect_levels(32'hF000_000F, 1'b1);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
